// File: rtl/proc_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : proc_trace_capture
// Purpose  : Processor instruction trace buffer. Once armed, it captures
//            {pc, wb_data} for each qualified write-back cycle, either
//            immediately or from the first cycle whose PC matches a trigger
//            PC. It stops when full (one-shot) or keeps overwriting the
//            oldest entry (circular) until stop is asserted.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            arm, stop       - start a new capture / end the capture
//            trig_en, trig_pc- PC-match trigger enable and trigger value
//            wrap_mode       - 0 one-shot, 1 circular
//            pc, wb_data,
//            wb_valid        - processor trace sample and its qualifier
//            rd_addr         - read index, 0 = oldest entry
//            rd_pc, rd_data  - registered read data
//            state, count,
//            done            - capture status
// Revision : 1.0 - initial release
// ============================================================================
module proc_trace_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  trig_en,
    input  logic [INST_WIDTH-1:0] trig_pc,
    input  logic                  wrap_mode,
    input  logic [INST_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         rd_addr,
    output logic [INST_WIDTH-1:0] rd_pc,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            state,
    output logic [AW:0]           count,
    output logic                  done
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_armed   = 2'd1;
    localparam logic [1:0] c_capture = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    localparam logic [AW:0] c_full      = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_full_m1   = (AW+1)'(DEPTH - 1);

    // Storage array, not reset.
    logic [INST_WIDTH-1:0] r_mem_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];

    logic [1:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_wrap;
    logic          r_trig_en;
    logic [INST_WIDTH-1:0] r_rd_pc;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [1:0]    w_nxt_state;
    logic          w_wr_en;
    logic          w_clr;
    logic          w_qualify;
    logic [AW-1:0] w_oldest;
    logic [AW-1:0] w_rd_idx;

    assign w_qualify = wb_valid & (~r_trig_en | (pc == trig_pc));

    // Next-state and write-enable decode. stop has priority over arming and
    // over any write in ARMED/CAPTURE; it has no effect in IDLE or DONE.
    always_comb begin
        w_nxt_state = r_state;
        w_wr_en     = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            c_idle: begin
                if (arm) begin
                    w_nxt_state = c_armed;
                    w_clr       = 1'b1;
                end
            end
            c_armed: begin
                if (stop) begin
                    w_nxt_state = c_done;
                end else if (w_qualify) begin
                    w_nxt_state = c_capture;
                    w_wr_en     = 1'b1;
                end
            end
            c_capture: begin
                if (stop) begin
                    w_nxt_state = c_done;
                end else if (wb_valid) begin
                    w_wr_en = 1'b1;
                    // One-shot: the write that fills the buffer ends capture.
                    if (!r_wrap && (r_count == c_full_m1)) begin
                        w_nxt_state = c_done;
                    end
                end
            end
            default: begin // c_done
                if (arm) begin
                    w_nxt_state = c_armed;
                    w_clr       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_wrap    <= 1'b0;
            r_trig_en <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if (w_clr) begin
                r_wr_ptr  <= '0;
                r_count   <= '0;
                // Capture mode is latched on entry to ARMED only.
                r_wrap    <= wrap_mode;
                r_trig_en <= trig_en;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count != c_full) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]   <= pc;
            r_mem_data[r_wr_ptr] <= wb_data;
        end
    end

    // Once the buffer has been filled, the oldest entry sits at the write
    // pointer; before that it is entry 0. AW-bit addition wraps modulo DEPTH.
    assign w_oldest = (r_count == c_full) ? r_wr_ptr : '0;
    assign w_rd_idx = w_oldest + rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pc   <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_pc   <= r_mem_pc[w_rd_idx];
            r_rd_data <= r_mem_data[w_rd_idx];
        end
    end

    assign rd_pc   = r_rd_pc;
    assign rd_data = r_rd_data;
    assign state   = r_state;
    assign count   = r_count;
    assign done    = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_proc_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_trace_capture
// Purpose  : Directed self-checking bench for proc_trace_capture (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_trace_capture;

    localparam int DW = 16;
    localparam int IW = 16;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          stop;
    logic          trig_en;
    logic [IW-1:0] trig_pc;
    logic          wrap_mode;
    logic [IW-1:0] pc;
    logic [DW-1:0] wb_data;
    logic          wb_valid;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_pc;
    logic [DW-1:0] rd_data;
    logic [1:0]    state;
    logic [AW:0]   count;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    proc_trace_capture #(
        .DATA_WIDTH (DW),
        .INST_WIDTH (IW),
        .DEPTH      (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .stop      (stop),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .wrap_mode (wrap_mode),
        .pc        (pc),
        .wb_data   (wb_data),
        .wb_valid  (wb_valid),
        .rd_addr   (rd_addr),
        .rd_pc     (rd_pc),
        .rd_data   (rd_data),
        .state     (state),
        .count     (count),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Drive one trace sample for the coming edge; data derived from pc.
    task automatic smp(input logic v, input logic [IW-1:0] p);
        wb_valid = v;
        pc       = p;
        wb_data  = p ^ 16'hA5A5;
    endtask

    task automatic chk_st(input string tag, input logic [1:0] s, input logic [AW:0] c);
        chk({tag, ".state"}, 32'(state), 32'(s));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".done"},  32'(done),  32'(s == 2'd3));
    endtask

    // Present rd_addr, advance one edge, compare registered read data.
    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] p);
        rd_addr = a;
        cyc();
        chk({tag, ".pc"},   32'(rd_pc),   32'(p));
        chk({tag, ".data"}, 32'(rd_data), 32'(p ^ 16'hA5A5));
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = '0;
        wrap_mode = 1'b0; rd_addr = '0;
        smp(1'b0, 16'h0);
        cyc(); cyc();
        chk_st("reset", 2'd0, 3'd0);
        chk("reset.rd_pc",   32'(rd_pc),   32'h0);
        chk("reset.rd_data", 32'(rd_data), 32'h0);
        rst = 1'b0;

        // stop in IDLE is ignored
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_st("idle_stop", 2'd0, 3'd0);

        // One-shot, immediate start: pc 0,2,4,6 fill, pc 8 dropped
        arm = 1'b1; cyc(); arm = 1'b0;
        chk_st("os.armed", 2'd1, 3'd0);
        smp(1'b1, 16'd0); cyc(); chk_st("os.w0", 2'd2, 3'd1);
        smp(1'b1, 16'd2); cyc(); chk_st("os.w1", 2'd2, 3'd2);
        smp(1'b1, 16'd4); cyc(); chk_st("os.w2", 2'd2, 3'd3);
        smp(1'b1, 16'd6); cyc(); chk_st("os.w3", 2'd3, 3'd4);
        smp(1'b1, 16'd8); cyc(); chk_st("os.frozen", 2'd3, 3'd4);
        smp(1'b0, 16'd0);
        rd("os.r0", 2'd0, 16'd0);
        rd("os.r1", 2'd1, 16'd2);
        rd("os.r2", 2'd2, 16'd4);
        rd("os.r3", 2'd3, 16'd6);

        // PC trigger at 0x0006
        trig_en = 1'b1; trig_pc = 16'h0006;
        arm = 1'b1; cyc(); arm = 1'b0;
        chk_st("tr.armed", 2'd1, 3'd0);
        smp(1'b1, 16'd0); cyc();
        smp(1'b1, 16'd2); cyc();
        smp(1'b1, 16'd4); cyc(); chk_st("tr.wait", 2'd1, 3'd0);
        smp(1'b1, 16'd6); cyc(); chk_st("tr.hit", 2'd2, 3'd1);
        smp(1'b1, 16'd8); cyc(); chk_st("tr.w1", 2'd2, 3'd2);
        smp(1'b1, 16'd10); stop = 1'b1; cyc(); stop = 1'b0;
        chk_st("tr.stop", 2'd3, 3'd2);
        smp(1'b0, 16'd0);
        rd("tr.r0", 2'd0, 16'd6);
        rd("tr.r1", 2'd1, 16'd8);

        // Circular: 6 writes, wrap_mode input dropped after arming
        trig_en = 1'b0; wrap_mode = 1'b1;
        arm = 1'b1; cyc(); arm = 1'b0;
        wrap_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            smp(1'b1, 16'(2 * i)); cyc();
        end
        chk_st("wr.full", 2'd2, 3'd4);
        smp(1'b0, 16'd0); stop = 1'b1; cyc(); stop = 1'b0;
        chk_st("wr.stop", 2'd3, 3'd4);
        rd("wr.r0", 2'd0, 16'd4);
        rd("wr.r1", 2'd1, 16'd6);
        rd("wr.r2", 2'd2, 16'd8);
        rd("wr.r3", 2'd3, 16'd10);

        // arm+stop together in ARMED, then gaps in CAPTURE
        arm = 1'b1; cyc();
        chk_st("as.armed", 2'd1, 3'd0);
        stop = 1'b1; smp(1'b1, 16'd40); cyc(); arm = 1'b0; stop = 1'b0;
        chk_st("as.done", 2'd3, 3'd0);
        arm = 1'b1; smp(1'b0, 16'd0); cyc(); arm = 1'b0;
        smp(1'b1, 16'd20); cyc();
        smp(1'b0, 16'd99); cyc(); chk_st("gap.a", 2'd2, 3'd1);
        smp(1'b1, 16'd22); cyc();
        smp(1'b0, 16'd98); cyc();
        smp(1'b0, 16'd97); cyc(); chk_st("gap.b", 2'd2, 3'd2);
        smp(1'b1, 16'd24); cyc();
        smp(1'b0, 16'd0); stop = 1'b1; cyc(); stop = 1'b0;
        chk_st("gap.stop", 2'd3, 3'd3);
        rd("gap.r0", 2'd0, 16'd20);
        rd("gap.r1", 2'd1, 16'd22);
        rd("gap.r2", 2'd2, 16'd24);

        // Asynchronous reset mid-capture
        arm = 1'b1; cyc(); arm = 1'b0;
        smp(1'b1, 16'd50); cyc();
        smp(1'b1, 16'd52); cyc();
        chk_st("ar.pre", 2'd2, 3'd2);
        #2 rst = 1'b1;
        #1;
        chk_st("ar.async", 2'd0, 3'd0);
        chk("ar.rd_pc", 32'(rd_pc), 32'h0);
        #1 rst = 1'b0;
        smp(1'b1, 16'd54); cyc();
        chk_st("ar.idle", 2'd0, 3'd0);
        arm = 1'b1; smp(1'b0, 16'd0); cyc(); arm = 1'b0;
        smp(1'b1, 16'd30); cyc();
        smp(1'b1, 16'd32); cyc();
        smp(1'b0, 16'd0); stop = 1'b1; cyc(); stop = 1'b0;
        chk_st("ar.recap", 2'd3, 3'd2);
        rd("ar.r0", 2'd0, 16'd30);
        rd("ar.r1", 2'd1, 16'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
